// File: rtl/ifetch_bridge.sv
// Instruction-fetch bridge between the fetch stage and a 64-bit AXI-style read port.
// Holds one fetched 64-bit word so the sibling 32-bit instruction can be served without a bus read.
module ifetch_bridge #(
  parameter bit          BUF_EN    = 1'b1,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] pc_i,
  input  logic        jump_en_i,
  input  logic        hazard_stop_i,
  input  logic        fence_i_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        ifetch_en_o,
  output logic        instr_err_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  output logic [63:0] araddr_o,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic [63:0] rdata_i,
  input  logic [1:0]  rresp_i
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StDrain,
    StResp
  } state_e;

  state_e state_q, state_d;

  logic [63:0] araddr_q, araddr_d;
  logic        half_q, half_d;
  logic        jump_seen_q, jump_seen_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic        buf_valid_q, buf_valid_d;
  logic [60:0] buf_tag_q, buf_tag_d;
  logic [63:0] buf_data_q, buf_data_d;

  logic buf_hit;
  logic beat_ok;
  logic unused_pc;

  assign unused_pc = ^pc_i[1:0];

  // A coincident fence_i must not be bypassed by a hit on the stale word.
  assign buf_hit = BUF_EN && buf_valid_q && !fence_i_i && (buf_tag_q == pc_i[63:3]);
  assign beat_ok = rvalid_i && (rresp_i == 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!jump_en_i) begin
          state_d = buf_hit ? StResp : StAddr;
        end
      end
      StAddr: begin
        // arvalid stays up until the handshake even when redirected; the beat is drained later.
        if (arready_i) begin
          state_d = (jump_seen_q || jump_en_i) ? StDrain : StData;
        end
      end
      StData: begin
        if (jump_en_i) begin
          state_d = rvalid_i ? StIdle : StDrain;
        end else if (rvalid_i) begin
          state_d = StResp;
        end
      end
      StDrain: begin
        if (rvalid_i) begin
          state_d = StIdle;
        end
      end
      StResp: begin
        if (jump_en_i || !hazard_stop_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and registered data
  always_comb begin
    arvalid_o     = (state_q == StAddr);
    rready_o      = (state_q == StData) || (state_q == StDrain);
    instr_valid_o = (state_q == StResp);
    ifetch_en_o   = instr_valid_o && !hazard_stop_i;
    instr_o       = instr_q;
    instr_err_o   = err_q;
    araddr_o      = araddr_q;
  end

  // Datapath next-state
  always_comb begin
    araddr_d    = araddr_q;
    half_d      = half_q;
    jump_seen_d = jump_seen_q;
    instr_d     = instr_q;
    err_d       = err_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;

    case (state_q)
      StIdle: begin
        if (!jump_en_i) begin
          if (buf_hit) begin
            instr_d = pc_i[2] ? buf_data_q[63:32] : buf_data_q[31:0];
            err_d   = 1'b0;
          end else begin
            araddr_d    = {pc_i[63:3], 3'b000};
            half_d      = pc_i[2];
            jump_seen_d = 1'b0;
          end
        end
      end
      StAddr: begin
        if (jump_en_i) begin
          jump_seen_d = 1'b1;
        end
      end
      StData: begin
        if (!jump_en_i && rvalid_i) begin
          if (beat_ok) begin
            instr_d = half_q ? rdata_i[63:32] : rdata_i[31:0];
            err_d   = 1'b0;
            if (BUF_EN) begin
              buf_valid_d = 1'b1;
              buf_tag_d   = araddr_q[63:3];
              buf_data_d  = rdata_i;
            end
          end else begin
            instr_d     = NOP_INSTR;
            err_d       = 1'b1;
            buf_valid_d = 1'b0;
          end
        end
      end
      default: ;
    endcase

    // Invalidate takes priority over a fill in the same cycle.
    if (fence_i_i) begin
      buf_valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      araddr_q    <= 64'd0;
      half_q      <= 1'b0;
      jump_seen_q <= 1'b0;
      instr_q     <= 32'd0;
      err_q       <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= 61'd0;
      buf_data_q  <= 64'd0;
    end else begin
      araddr_q    <= araddr_d;
      half_q      <= half_d;
      jump_seen_q <= jump_seen_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end

endmodule
